ov7670_frame_emitter: RTL and testbench

Drives OV7670-style parallel video (vsync, href, 8-bit d) from a 320x240 grayscale frame buffer, one byte per pclk, in YCbCr422 byte order with constant chroma. It is the transmit side of the camera bus. It feeds the grayscale capture path in loopback and simulation without a physical sensor, and replays stored frames into the FAST detector pipeline.

---
 rtl/ov7670_frame_emitter.sv | 148 ++++++++++++++
 tb/tb_ov7670_frame_emitter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_frame_emitter.sv
// Replays a grayscale frame buffer onto an OV7670-style parallel bus (vsync, href, d)
// in YCbCr422 byte order with constant chroma, one byte per pclk.
module ov7670_frame_emitter #(
   parameter int         H_ACTIVE    = 320,
   parameter int         V_ACTIVE    = 240,
   parameter int         H_BLANK     = 144,
   parameter int         VSYNC_LINES = 3,
   parameter int         VBP_LINES   = 17,
   parameter int         VFP_LINES   = 10,
   parameter logic [7:0] CHROMA      = 8'h80
) (
   input  logic        pclk,
   input  logic        reset,
   input  logic        start,
   input  logic        continuous,
   output logic        rd_en,
   output logic [16:0] rd_addr,
   input  logic [7:0]  rd_data,
   output logic        vsync,
   output logic        href,
   output logic [7:0]  d,
   output logic        busy,
   output logic        frame_done,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_VSYNC  = 3'd1,
      S_VBP    = 3'd2,
      S_ACTIVE = 3'd3,
      S_VFP    = 3'd4
   } state_t;

   localparam logic [10:0] COL_LAST = 11'(2 * H_ACTIVE + H_BLANK - 1);
   localparam logic [10:0] COL_PRE  = 11'(2 * H_ACTIVE + H_BLANK - 2);
   localparam logic [10:0] ACT_COLS = 11'(2 * H_ACTIVE);
   localparam logic [10:0] RD_LIM   = 11'(2 * H_ACTIVE - 2);
   localparam logic [8:0]  VS_LAST  = 9'(VSYNC_LINES - 1);
   localparam logic [8:0]  VBP_LAST = 9'(VBP_LINES - 1);
   localparam logic [8:0]  ACT_LAST = 9'(V_ACTIVE - 1);
   localparam logic [8:0]  VFP_LAST = 9'(VFP_LINES - 1);

   // Position registers describe the cycle currently on the bus.
   state_t      state_q, state_d;
   logic [10:0] col_q, col_d;
   logic [8:0]  line_q, line_d;

   logic        vsync_q, vsync_d;
   logic        href_q, href_d;
   logic [7:0]  d_q, d_d;
   logic        rd_en_q, rd_en_d;
   logic [16:0] rd_addr_q, rd_addr_d;
   logic        busy_q, busy_d;
   logic        frame_done_q, frame_done_d;

   logic        eol;
   logic [8:0]  seg_last;
   state_t      seg_next;

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      line_d   = line_q;
      eol      = (col_q == COL_LAST);
      seg_last = 9'd0;
      seg_next = S_IDLE;
      case (state_q)
         S_VSYNC:  begin seg_last = VS_LAST;  seg_next = S_VBP;    end
         S_VBP:    begin seg_last = VBP_LAST; seg_next = S_ACTIVE; end
         S_ACTIVE: begin seg_last = ACT_LAST; seg_next = S_VFP;    end
         S_VFP:    begin seg_last = VFP_LAST; seg_next = continuous ? S_VSYNC : S_IDLE; end
         default:  begin seg_last = 9'd0;     seg_next = S_IDLE;   end
      endcase

      if (state_q == S_IDLE) begin
         col_d  = 11'd0;
         line_d = 9'd0;
         if (start) state_d = S_VSYNC;
      end else begin
         col_d = eol ? 11'd0 : col_q + 11'd1;
         if (eol) begin
            if (line_q == seg_last) begin
               line_d  = 9'd0;
               state_d = seg_next;
            end else begin
               line_d = line_q + 9'd1;
            end
         end
      end
   end

   // Outputs are registered from the next position so they line up with the counters.
   // A read is issued two cycles ahead of its Y slot: the pixel at column c+2, or the
   // first pixel of the next active line when sitting at column L-2.
   always_comb begin
      vsync_d      = (state_d == S_VSYNC);
      href_d       = (state_d == S_ACTIVE) && (col_d < ACT_COLS);
      d_d          = 8'h00;
      if (href_d) d_d = col_d[0] ? CHROMA : rd_data;
      rd_en_d      = ((state_d == S_ACTIVE) && !col_d[0] && (col_d < RD_LIM)) ||
                     ((col_d == COL_PRE) &&
                      (((state_d == S_VBP) && (line_d == VBP_LAST)) ||
                       ((state_d == S_ACTIVE) && (line_d != ACT_LAST))));
      busy_d       = (state_d != S_IDLE);
      frame_done_d = (state_d == S_VFP) && (line_d == VFP_LAST) && (col_d == COL_LAST);
      rd_addr_d    = rd_addr_q;
      // The single VBP read is pixel 0; every later read advances, so the last stays in range.
      if ((state_d == S_VSYNC) && (state_q != S_VSYNC)) rd_addr_d = 17'd0;
      else if (rd_en_d && (state_d == S_ACTIVE))        rd_addr_d = rd_addr_q + 17'd1;
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         col_q        <= 11'd0;
         line_q       <= 9'd0;
         vsync_q      <= 1'b0;
         href_q       <= 1'b0;
         d_q          <= 8'h00;
         rd_en_q      <= 1'b0;
         rd_addr_q    <= 17'd0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         line_q       <= line_d;
         vsync_q      <= vsync_d;
         href_q       <= href_d;
         d_q          <= d_d;
         rd_en_q      <= rd_en_d;
         rd_addr_q    <= rd_addr_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign vsync      = vsync_q;
   assign href       = href_q;
   assign d          = d_q;
   assign rd_en      = rd_en_q;
   assign rd_addr    = rd_addr_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_ov7670_frame_emitter.sv
// Bench for ov7670_frame_emitter with a small frame geometry; every bus cycle is compared
// against a frame model computed from line/column arithmetic.
module tb_ov7670_frame_emitter;

   localparam int H   = 4;
   localparam int V   = 3;
   localparam int HB  = 2;
   localparam int VS  = 1;
   localparam int VBP = 1;
   localparam int VFP = 1;
   localparam int L   = 2 * H + HB;
   localparam int FL  = (VS + VBP + V + VFP) * L;
   localparam logic [7:0] CHR = 8'h80;

   logic        pclk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        continuous = 1'b0;
   logic        rd_en;
   logic [16:0] rd_addr;
   logic [7:0]  rd_data = 8'h00;
   logic        vsync, href, busy, frame_done;
   logic [7:0]  d;
   logic [2:0]  dbg_state;

   logic [7:0]  mem [0:H*V-1];
   int          n_checks = 0;
   int          n_fail = 0;

   ov7670_frame_emitter #(
      .H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB),
      .VSYNC_LINES(VS), .VBP_LINES(VBP), .VFP_LINES(VFP), .CHROMA(CHR)
   ) dut (
      .pclk(pclk), .reset(reset), .start(start), .continuous(continuous),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .vsync(vsync), .href(href), .d(d), .busy(busy), .frame_done(frame_done),
      .dbg_state(dbg_state)
   );

   always #5 pclk = ~pclk;

   // Frame buffer: data valid one pclk after the read strobe.
   always @(posedge pclk) if (rd_en) rd_data <= mem[rd_addr];

   // Frame cycle k counts from 1 (first vsync cycle) to FL (frame_done cycle).
   function automatic bit is_y(input int k);
      int pos, lp, col, al;
      if (k < 1 || k > FL) return 1'b0;
      pos = k - 1; lp = pos / L; col = pos % L; al = lp - VS - VBP;
      return (al >= 0) && (al < V) && (col < 2 * H) && (col % 2 == 0);
   endfunction

   function automatic int pix(input int k);
      int pos, lp, col;
      pos = k - 1; lp = pos / L; col = pos % L;
      return (lp - VS - VBP) * H + col / 2;
   endfunction

   function automatic logic [29:0] model_vec(input int k);
      int pos, lp, col, al;
      logic vs, hr, re;
      logic [7:0] dd;
      logic [16:0] ad;
      pos = k - 1; lp = pos / L; col = pos % L; al = lp - VS - VBP;
      vs = (lp < VS);
      hr = (al >= 0) && (al < V) && (col < 2 * H);
      dd = 8'h00;
      if (hr) dd = (col % 2 == 1) ? CHR : mem[al * H + col / 2];
      re = is_y(k + 2);
      ad = re ? 17'(pix(k + 2)) : 17'd0;
      return {vs, hr, dd, re, 1'b1, (k == FL), ad};
   endfunction

   function automatic logic [29:0] obs_vec();
      return {vsync, href, d, rd_en, busy, frame_done, rd_en ? rd_addr : 17'd0};
   endfunction

   task automatic fill_mem(input bit ramp);
      for (int i = 0; i < H * V; i++) mem[i] = ramp ? 8'(i + 8'h10) : 8'($urandom_range(0, 255));
   endtask

   // Caller positions the bench #1 after the edge that begins frame cycle 1.
   task automatic check_frame(input string tag, input bit cont_last);
      logic [16:0] exp_q[$];
      logic [16:0] e;
      logic [29:0] ev, ov;
      int rd_cnt, href_cnt;
      rd_cnt = 0; href_cnt = 0;
      for (int k = 1; k <= FL; k++) if (is_y(k + 2)) exp_q.push_back(17'(pix(k + 2)));
      for (int k = 1; k <= FL; k++) begin
         continuous = (k == FL) ? cont_last : 1'($urandom_range(0, 1));
         ev = model_vec(k);
         ov = obs_vec();
         n_checks++;
         if (ov !== ev) begin
            n_fail++;
            $display("FAIL %s_bus cycle %0d: got %h expected %h", tag, k, ov, ev);
         end
         if (href === 1'b1) href_cnt++;
         if (rd_en === 1'b1) begin
            rd_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL %s_rdaddr cycle %0d: got extra read %0d expected none", tag, k, rd_addr);
            end else begin
               e = exp_q.pop_front();
               if (rd_addr !== e) begin
                  n_fail++;
                  $display("FAIL %s_rdaddr cycle %0d: got %0d expected %0d", tag, k, rd_addr, e);
               end
            end
         end
         @(posedge pclk); #1;
      end
      n_checks++;
      if (rd_cnt != H * V) begin
         n_fail++;
         $display("FAIL %s_rdcount: got %0d expected %0d", tag, rd_cnt, H * V);
      end
      n_checks++;
      if (href_cnt != 2 * H * V) begin
         n_fail++;
         $display("FAIL %s_hrefcount: got %0d expected %0d", tag, href_cnt, 2 * H * V);
      end
   endtask

   task automatic check_idle(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         n_checks++;
         if (obs_vec() !== 30'd0) begin
            n_fail++;
            $display("FAIL %s idle cycle %0d: got %h expected 0", tag, i, obs_vec());
         end
         @(posedge pclk); #1;
      end
   endtask

   task automatic start_pulse();
      start = 1'b1;
      @(posedge pclk); #1;
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1;
      repeat (3) @(posedge pclk);
      #1;
      n_checks++;
      if ({obs_vec(), rd_addr} !== 47'd0) begin
         n_fail++;
         $display("FAIL reset_values: got %h addr %0d expected all 0", obs_vec(), rd_addr);
      end
      reset = 1'b0; start = 1'b0;
      @(posedge pclk); #1;
      check_idle("post_reset", 5);
   endtask

   task automatic test_single_frame();
      fill_mem(1'b1);
      start_pulse();
      check_frame("ramp", 1'b0);
      check_idle("after_ramp", 8);
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 3; f++) begin
         fill_mem(1'b0);
         start_pulse();
         check_frame("rand", 1'b0);
         check_idle("after_rand", $urandom_range(1, 6));
      end
   endtask

   task automatic test_back_to_back();
      fill_mem(1'b0);
      start_pulse();
      check_frame("cont1", 1'b1);
      check_frame("cont2", 1'b0);
      check_idle("after_cont", 8);
   endtask

   task automatic test_reset_mid_frame();
      logic [29:0] ev;
      fill_mem(1'b0);
      start_pulse();
      for (int k = 1; k <= (VS + VBP + 1) * L + 4; k++) begin
         ev = model_vec(k);
         n_checks++;
         if (obs_vec() !== ev) begin
            n_fail++;
            $display("FAIL midrst_bus cycle %0d: got %h expected %h", k, obs_vec(), ev);
         end
         if (k == (VS + VBP + 1) * L + 4) reset = 1'b1;
         @(posedge pclk); #1;
      end
      n_checks++;
      if ({obs_vec(), rd_addr} !== 47'd0) begin
         n_fail++;
         $display("FAIL midrst_abort: got %h addr %0d expected all 0", obs_vec(), rd_addr);
      end
      reset = 1'b0;
      @(posedge pclk); #1;
      check_idle("midrst_idle", FL + 10);
      fill_mem(1'b0);
      start_pulse();
      check_frame("midrst_clean", 1'b0);
      check_idle("after_midrst", 4);
   endtask

   task automatic test_start_held();
      fill_mem(1'b0);
      start = 1'b1;
      @(posedge pclk); #1;
      check_frame("held", 1'b0);
      n_checks++;
      if ({busy, vsync, href, frame_done} !== 4'b0000) begin
         n_fail++;
         $display("FAIL held_idle: got busy=%b vsync=%b href=%b fd=%b expected 0", busy, vsync, href, frame_done);
      end
      @(posedge pclk); #1;
      start = 1'b0;
      check_frame("held_restart", 1'b0);
      check_idle("after_held", 6);
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_random_frames();
      test_back_to_back();
      test_reset_mid_frame();
      test_start_held();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
